// File: rtl/truth_table_checker.sv
// truth_table_checker: on-chip self-test sequencer that sweeps all 2**N_IN input vectors of a
// 1-output combinational block and compares against EXPECTED. Option: TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN.
module truth_table_checker #(
  parameter int                 N_IN     = 3,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'h31,
  parameter int                 SETTLE   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid
);

  localparam int              FCW       = N_IN + 1;
  localparam logic [FCW-1:0]  FAIL_MAX  = FCW'(2**N_IN);
  localparam logic [FCW-1:0]  FC_ZERO   = {FCW{1'b0}};
  localparam logic [FCW-1:0]  FC_ONE    = FCW'(1);
  localparam logic [N_IN-1:0] VEC_ZERO  = {N_IN{1'b0}};
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
  localparam bit              STOP_ON_FAIL = 1'b1;
`else
  localparam bit              STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [3:0]      cnt_r, cnt_s;
  logic [N_IN-1:0] dut_in_r, dut_in_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            pass_r, pass_s;
  logic [FCW-1:0]  fail_count_r, fail_count_s;
  logic [N_IN-1:0] first_fail_r, first_fail_s;
  logic            first_fail_valid_r, first_fail_valid_s;
  logic            mismatch_s;
  logic [FCW-1:0]  fail_inc_s;

  // Case inequality so an unknown dut_y is flagged as a mismatch in simulation.
  assign mismatch_s = (dut_y !== EXPECTED[dut_in_r]);
  assign fail_inc_s = (fail_count_r == FAIL_MAX) ? fail_count_r : (fail_count_r + FC_ONE);

  // Next-state and next-result logic for the sweep sequencer
  always_comb begin
    state_s            = state_r;
    cnt_s              = cnt_r;
    dut_in_s           = dut_in_r;
    busy_s             = busy_r;
    done_s             = done_r;
    pass_s             = pass_r;
    fail_count_s       = fail_count_r;
    first_fail_s       = first_fail_r;
    first_fail_valid_s = first_fail_valid_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          dut_in_s           = VEC_ZERO;
          cnt_s              = SETTLE_LD;
          busy_s             = 1'b1;
          done_s             = 1'b0;
          pass_s             = 1'b0;
          fail_count_s       = FC_ZERO;
          first_fail_s       = VEC_ZERO;
          first_fail_valid_s = 1'b0;
          state_s            = ST_SETTLE;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_CHECK;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch_s) begin
          fail_count_s = fail_inc_s;
          if (!first_fail_valid_r) begin
            first_fail_s       = dut_in_r;
            first_fail_valid_s = 1'b1;
          end else begin
            first_fail_s = first_fail_r;
          end
        end else begin
          fail_count_s = fail_count_r;
        end
        // pass uses the count including this vector's result
        if ((dut_in_r == VEC_LAST) || (STOP_ON_FAIL && mismatch_s)) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (fail_count_s == FC_ZERO);
        end else begin
          dut_in_s = dut_in_r + VEC_ONE;
          cnt_s    = SETTLE_LD;
          state_s  = ST_SETTLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r            <= ST_IDLE;
      cnt_r              <= 4'd0;
      dut_in_r           <= VEC_ZERO;
      busy_r             <= 1'b0;
      done_r             <= 1'b0;
      pass_r             <= 1'b0;
      fail_count_r       <= FC_ZERO;
      first_fail_r       <= VEC_ZERO;
      first_fail_valid_r <= 1'b0;
    end else begin
      state_r            <= state_s;
      cnt_r              <= cnt_s;
      dut_in_r           <= dut_in_s;
      busy_r             <= busy_s;
      done_r             <= done_s;
      pass_r             <= pass_s;
      fail_count_r       <= fail_count_s;
      first_fail_r       <= first_fail_s;
      first_fail_valid_r <= first_fail_valid_s;
    end
  end

  assign dut_in           = dut_in_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign fail_count       = fail_count_r;
  assign first_fail       = first_fail_r;
  assign first_fail_valid = first_fail_valid_r;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: three instances (SETTLE = 1, 0, 3) driven by
// behavioural DUT models; expected results are predicted at start and checked when done rises.
module tb_truth_table_checker;

  localparam int NK = 3;
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  typedef struct {
    int         cycles;
    logic [3:0] fc;
    logic [2:0] ff;
    logic       ffv;
    logic       pass;
    logic [2:0] last_in;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a  [NK];
  logic       glitch_a [NK];
  logic [2:0] dut_in_a [NK];
  logic       dut_y_a  [NK];
  logic       busy_a   [NK];
  logic       done_a   [NK];
  logic       pass_a   [NK];
  logic       ffv_a    [NK];
  logic [3:0] fc_a     [NK];
  logic [2:0] ff_a     [NK];
  int         mode;
  int         checks   = 0;
  int         failures = 0;
  exp_t       sb [$];

  always #5 clk = ~clk;

  // Reference function y = ~b & (~c | a), vector = {a, b, c}
  function automatic logic ref_y(input logic [2:0] v);
    return ~v[1] & (~v[0] | v[2]);
  endfunction

  // mode 0: correct, 1: stuck-at-1, 2: inverted
  function automatic logic model_y(input int m, input logic [2:0] v);
    case (m)
      1:       return 1'b1;
      2:       return ~ref_y(v);
      default: return ref_y(v);
    endcase
  endfunction

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic exp_t predict(input int m, input int s);
    exp_t e;
    int   fc;
    fc = 0;
    e.ff = 3'd0; e.ffv = 1'b0; e.cycles = 0; e.last_in = 3'd0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      e.cycles  += s + 2;
      e.last_in  = v;
      if (model_y(m, v) != ref_y(v)) begin
        fc++;
        if (!e.ffv) begin
          e.ff  = v;
          e.ffv = 1'b1;
        end
        if (STOP_EN) break;
      end
    end
    e.fc   = 4'(fc);
    e.pass = (fc == 0);
    return e;
  endfunction

  for (genvar g = 0; g < NK; g++) begin : g_dut
    assign dut_y_a[g] = model_y(mode, dut_in_a[g]) ^ glitch_a[g];
    truth_table_checker #(
      .N_IN(3), .EXPECTED(8'h31), .SETTLE((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk(clk), .reset(reset), .start(start_a[g]), .dut_in(dut_in_a[g]), .dut_y(dut_y_a[g]),
      .busy(busy_a[g]), .done(done_a[g]), .pass(pass_a[g]), .fail_count(fc_a[g]),
      .first_fail(ff_a[g]), .first_fail_valid(ffv_a[g])
    );
  end

  task automatic check_cleared(input string name, input int k);
    checks++;
    if (dut_in_a[k] !== 3'd0 || busy_a[k] !== 1'b0 || done_a[k] !== 1'b0 || pass_a[k] !== 1'b0 ||
        fc_a[k] !== 4'd0 || ff_a[k] !== 3'd0 || ffv_a[k] !== 1'b0) begin
      failures++;
      $display("FAIL %s inst=%0d got dut_in=%0d busy=%b done=%b pass=%b fc=%0d ff=%0d ffv=%b required all 0",
               name, k, dut_in_a[k], busy_a[k], done_a[k], pass_a[k], fc_a[k], ff_a[k], ffv_a[k]);
    end
  endtask

  task automatic run_sweep(input string name, input int k, input int m, input bit glitch_en,
                           input bit hold_start);
    exp_t       e;
    int         s, cyc, p;
    logic [2:0] want_in;
    s    = settle_of(k);
    mode = m;
    sb.push_back(predict(m, s));
    @(negedge clk); start_a[k] = 1'b1;
    @(negedge clk); start_a[k] = 1'b0;
    cyc = 0;
    while (!done_a[k] && cyc < 400) begin
      p           = cyc % (s + 2);
      glitch_a[k] = glitch_en && (p <= s);
      start_a[k]  = hold_start && (cyc >= 2) && (cyc < 8);
      want_in     = 3'(cyc / (s + 2));
      checks++;
      if (dut_in_a[k] !== want_in || busy_a[k] !== 1'b1) begin
        failures++;
        $display("FAIL %s sweep cyc=%0d got dut_in=%0d busy=%b required dut_in=%0d busy=1",
                 name, cyc, dut_in_a[k], busy_a[k], want_in);
      end
      @(negedge clk);
      cyc++;
    end
    glitch_a[k] = 1'b0;
    start_a[k]  = 1'b0;
    e = sb.pop_front();
    checks++;
    if (done_a[k] !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout done=%b after %0d cycles required done=1", name, done_a[k], cyc);
    end
    checks++;
    if (cyc != e.cycles) begin
      failures++;
      $display("FAIL %s latency got=%0d required=%0d", name, cyc, e.cycles);
    end
    checks++;
    if (fc_a[k] !== e.fc || ff_a[k] !== e.ff || ffv_a[k] !== e.ffv || pass_a[k] !== e.pass) begin
      failures++;
      $display("FAIL %s results got fc=%0d ff=%0d ffv=%b pass=%b required fc=%0d ff=%0d ffv=%b pass=%b",
               name, fc_a[k], ff_a[k], ffv_a[k], pass_a[k], e.fc, e.ff, e.ffv, e.pass);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (dut_in_a[k] !== e.last_in || busy_a[k] !== 1'b0 || done_a[k] !== 1'b1) begin
      failures++;
      $display("FAIL %s hold got dut_in=%0d busy=%b done=%b required dut_in=%0d busy=0 done=1",
               name, dut_in_a[k], busy_a[k], done_a[k], e.last_in);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NK; k++) check_cleared("reset_state", k);
    reset = 1'b0;
  endtask

  task automatic test_correct;
    run_sweep("correct", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stuck;
    run_sweep("stuck1", 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_inverted;
    run_sweep("inverted", 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_settle;
    run_sweep("settle0_glitch", 1, 0, 1'b1, 1'b0);
    run_sweep("settle3_glitch", 2, 0, 1'b1, 1'b0);
    run_sweep("settle1_glitch", 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    int cyc;
    mode = 0;
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    cyc = 0;
    while (dut_in_a[0] !== 3'd4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (dut_in_a[0] !== 3'd4) begin
      failures++;
      $display("FAIL reset_mid reach got dut_in=%0d required 4", dut_in_a[0]);
    end
    reset = 1'b1;
    #1;
    check_cleared("reset_mid_async", 0);
    @(negedge clk);
    check_cleared("reset_mid_held", 0);
    reset = 1'b0;
    run_sweep("after_reset", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_start_held;
    run_sweep("start_held", 0, 1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_sweep("b2b_inverted", 0, 2, 1'b0, 1'b0);
    run_sweep("b2b_correct", 0, 0, 1'b0, 1'b0);
    run_sweep("b2b_settle3_stuck", 2, 1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    mode  = 0;
    for (int k = 0; k < NK; k++) begin
      start_a[k]  = 1'b0;
      glitch_a[k] = 1'b0;
    end
    test_reset();
    test_correct();
    test_stuck();
    test_inverted();
    test_settle();
    test_reset_mid();
    test_start_held();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
